riscvsys_ev_mon: RTL and testbench
==================================

# riscvsys_ev_mon

Per-instruction event monitor for the picorv32 core in the riscvsys simulation system. It watches the core's one-hot instruction-decode flags and instruction-launch strobe. For every launched instruction it emits a registered single-cycle pulse on the matching event output. The pulses feed event counters, waveform probes and the system-level `ev_*` nets.

## Interface

Parameters:
- `PC_W`, default 32: width of the program-counter inputs.

Ports:
- `i_clk`, input, 1: the single clock; all state is on its rising edge.
- `i_rst`, input, 1: reset, asynchronous, active-high; clears all state.
- `i_instr_<n>`, input, 1 each: decode flag from the core, high while instruction class `<n>` is decoded/executing. `<n>` is one of the 49 names: lui auipc jal jalr beq bne blt bge bltu bgeu lb lh lw lbu lhu sb sh sw addi slti sltiu xori ori andi slli srli srai add sub sll slt sltu xor srl sra or and rdcycle rdcycleh rdinstr rdinstrh ecall_ebreak getq setq retirq maskirq waitirq timer trap.
- `i_pc`, input, `PC_W`: current PC (`reg_pc`). Captured only; it does not affect event outputs.
- `i_next_pc`, input, `PC_W`: next PC (`reg_next_pc`). Captured only; it does not affect event outputs.
- `i_dbg_next`, input, 1: instruction-launch strobe (`dbg_next`). High for one cycle when a new instruction's decode flags become valid.
- `ev_<n>`, output, 1 each: event pulse, one per `i_instr_<n>`, same 49 names.

## Operation

- Event rule, evaluated independently for each of the 49 names `<n>`:
  - `ev_<n>` next value = `i_dbg_next & i_instr_<n>`.
  - The result is registered and driven from a flop.
- Decode flags alone never produce an event.
  - Core flags stay high for all cycles of a multi-cycle instruction (loads, stores, shifts, mul/div, stalls).
  - Gating with `i_dbg_next` therefore yields exactly one pulse per launched instruction.
- No one-hot checking. If several flags are high on a launch cycle, every matching output pulses in the same cycle.
- If `i_dbg_next` is high and no flag is high (e.g. compressed or mul/div ops without a dedicated flag), no output pulses.
- PC tracking:
  - On each launch, `i_pc` and `i_next_pc` are captured into internal registers `last_pc` and `last_next_pc`.
  - These are visible hierarchically for debug only.
  - They do not affect any `ev_*` output.
- No internal counters and no saturation behaviour; counting is the consumer's job.
- Purely passive: no outputs return to the core, and the core's behaviour is unaffected.

## Timing

- Latency is 1 cycle. A launch at rising edge k (inputs sampled) produces `ev_<n>` high from edge k until edge k+1.
- Pulse width:
  - Exactly 1 cycle per launch.
  - Back-to-back launches on consecutive cycles give back-to-back pulses with no gap.
  - The same instruction class launched twice in a row keeps `ev_<n>` high for 2 cycles.
- Reset:
  - While `i_rst` is high, every `ev_*` output is 0 and `last_pc`/`last_next_pc` are 0.
  - Assertion clears outputs immediately, without waiting for a clock edge.
  - A pulse in flight when reset asserts is dropped.
  - The first possible pulse after deassertion is one cycle after the first sampled `i_dbg_next` = 1.
- Inputs are assumed synchronous to `i_clk`. There is no input registering beyond the single output stage.

## Test plan

- Reset:
  - Stimulus: assert `i_rst` asynchronously mid-cycle while `ev_add` = 1.
  - Required: `ev_add` falls to 0 before the next edge; all 49 outputs stay 0 during reset even with `i_dbg_next` = 1 and `i_instr_add` = 1.
- Single launch:
  - Stimulus: `i_instr_addi` = 1, `i_dbg_next` = 1 for one cycle at edge 5.
  - Required: `ev_addi` = 1 during cycle 6 only; every other output = 0.
- Multi-cycle hold:
  - Stimulus: `i_instr_lw` held high for 6 cycles, `i_dbg_next` high only in the first.
  - Required: exactly one `ev_lw` pulse, 1 cycle wide.
- Back-to-back:
  - Stimulus: launches of sw, sw, beq on 3 consecutive cycles.
  - Required: `ev_sw` high for 2 cycles, then `ev_beq` high for 1 cycle, with no gaps.
- Simultaneous flags and unmatched launch:
  - Stimulus: `i_instr_jal` and `i_instr_trap` both high with `i_dbg_next`.
  - Required: `ev_jal` and `ev_trap` pulse together.
  - Stimulus: `i_dbg_next` = 1 with all flags 0.
  - Required: no pulse.
- PC capture:
  - Stimulus: launch with `i_pc` = 0x0000_0100, `i_next_pc` = 0x0000_0104.
  - Required: `last_pc`/`last_next_pc` read those values afterwards; event outputs are identical with any PC values.

Source files
------------

// File: rtl/riscvsys_ev_mon.sv
// Per-instruction event monitor for picorv32: one registered pulse per launched
// instruction on the event output matching each asserted decode flag.
module riscvsys_ev_mon #(
  parameter int PC_W = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_instr_lui,
  input  logic            i_instr_auipc,
  input  logic            i_instr_jal,
  input  logic            i_instr_jalr,
  input  logic            i_instr_beq,
  input  logic            i_instr_bne,
  input  logic            i_instr_blt,
  input  logic            i_instr_bge,
  input  logic            i_instr_bltu,
  input  logic            i_instr_bgeu,
  input  logic            i_instr_lb,
  input  logic            i_instr_lh,
  input  logic            i_instr_lw,
  input  logic            i_instr_lbu,
  input  logic            i_instr_lhu,
  input  logic            i_instr_sb,
  input  logic            i_instr_sh,
  input  logic            i_instr_sw,
  input  logic            i_instr_addi,
  input  logic            i_instr_slti,
  input  logic            i_instr_sltiu,
  input  logic            i_instr_xori,
  input  logic            i_instr_ori,
  input  logic            i_instr_andi,
  input  logic            i_instr_slli,
  input  logic            i_instr_srli,
  input  logic            i_instr_srai,
  input  logic            i_instr_add,
  input  logic            i_instr_sub,
  input  logic            i_instr_sll,
  input  logic            i_instr_slt,
  input  logic            i_instr_sltu,
  input  logic            i_instr_xor,
  input  logic            i_instr_srl,
  input  logic            i_instr_sra,
  input  logic            i_instr_or,
  input  logic            i_instr_and,
  input  logic            i_instr_rdcycle,
  input  logic            i_instr_rdcycleh,
  input  logic            i_instr_rdinstr,
  input  logic            i_instr_rdinstrh,
  input  logic            i_instr_ecall_ebreak,
  input  logic            i_instr_getq,
  input  logic            i_instr_setq,
  input  logic            i_instr_retirq,
  input  logic            i_instr_maskirq,
  input  logic            i_instr_waitirq,
  input  logic            i_instr_timer,
  input  logic            i_instr_trap,
  input  logic [PC_W-1:0] i_pc,
  input  logic [PC_W-1:0] i_next_pc,
  input  logic            i_dbg_next,
  output logic            ev_lui,
  output logic            ev_auipc,
  output logic            ev_jal,
  output logic            ev_jalr,
  output logic            ev_beq,
  output logic            ev_bne,
  output logic            ev_blt,
  output logic            ev_bge,
  output logic            ev_bltu,
  output logic            ev_bgeu,
  output logic            ev_lb,
  output logic            ev_lh,
  output logic            ev_lw,
  output logic            ev_lbu,
  output logic            ev_lhu,
  output logic            ev_sb,
  output logic            ev_sh,
  output logic            ev_sw,
  output logic            ev_addi,
  output logic            ev_slti,
  output logic            ev_sltiu,
  output logic            ev_xori,
  output logic            ev_ori,
  output logic            ev_andi,
  output logic            ev_slli,
  output logic            ev_srli,
  output logic            ev_srai,
  output logic            ev_add,
  output logic            ev_sub,
  output logic            ev_sll,
  output logic            ev_slt,
  output logic            ev_sltu,
  output logic            ev_xor,
  output logic            ev_srl,
  output logic            ev_sra,
  output logic            ev_or,
  output logic            ev_and,
  output logic            ev_rdcycle,
  output logic            ev_rdcycleh,
  output logic            ev_rdinstr,
  output logic            ev_rdinstrh,
  output logic            ev_ecall_ebreak,
  output logic            ev_getq,
  output logic            ev_setq,
  output logic            ev_retirq,
  output logic            ev_maskirq,
  output logic            ev_waitirq,
  output logic            ev_timer,
  output logic            ev_trap
);

  localparam int NUM_EV = 49;

  logic [NUM_EV-1:0] flags;
  logic [NUM_EV-1:0] ev_q;
  logic [PC_W-1:0]   last_pc;
  logic [PC_W-1:0]   last_next_pc;

  assign flags = {i_instr_trap, i_instr_timer, i_instr_waitirq, i_instr_maskirq,
                  i_instr_retirq, i_instr_setq, i_instr_getq, i_instr_ecall_ebreak,
                  i_instr_rdinstrh, i_instr_rdinstr, i_instr_rdcycleh, i_instr_rdcycle,
                  i_instr_and, i_instr_or, i_instr_sra, i_instr_srl,
                  i_instr_xor, i_instr_sltu, i_instr_slt, i_instr_sll,
                  i_instr_sub, i_instr_add, i_instr_srai, i_instr_srli,
                  i_instr_slli, i_instr_andi, i_instr_ori, i_instr_xori,
                  i_instr_sltiu, i_instr_slti, i_instr_addi, i_instr_sw,
                  i_instr_sh, i_instr_sb, i_instr_lhu, i_instr_lbu,
                  i_instr_lw, i_instr_lh, i_instr_lb, i_instr_bgeu,
                  i_instr_bltu, i_instr_bge, i_instr_blt, i_instr_bne,
                  i_instr_beq, i_instr_jalr, i_instr_jal, i_instr_auipc,
                  i_instr_lui};

  // Flags stay high across multi-cycle instructions, so only the launch strobe
  // may turn them into events; PCs are kept for debug visibility only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ev_q         <= '0;
      last_pc      <= '0;
      last_next_pc <= '0;
    end else begin
      ev_q <= flags & {NUM_EV{i_dbg_next}};
      if (i_dbg_next) begin
        last_pc      <= i_pc;
        last_next_pc <= i_next_pc;
      end
    end
  end

  assign {ev_trap, ev_timer, ev_waitirq, ev_maskirq,
          ev_retirq, ev_setq, ev_getq, ev_ecall_ebreak,
          ev_rdinstrh, ev_rdinstr, ev_rdcycleh, ev_rdcycle,
          ev_and, ev_or, ev_sra, ev_srl,
          ev_xor, ev_sltu, ev_slt, ev_sll,
          ev_sub, ev_add, ev_srai, ev_srli,
          ev_slli, ev_andi, ev_ori, ev_xori,
          ev_sltiu, ev_slti, ev_addi, ev_sw,
          ev_sh, ev_sb, ev_lhu, ev_lbu,
          ev_lw, ev_lh, ev_lb, ev_bgeu,
          ev_bltu, ev_bge, ev_blt, ev_bne,
          ev_beq, ev_jalr, ev_jal, ev_auipc,
          ev_lui} = ev_q;

endmodule

// File: tb/tb_riscvsys_ev_mon.sv
// Self-checking bench for riscvsys_ev_mon: table vectors, hand-written
// multi-cycle sequences and randomized launches against a behavioural model.
module tb_riscvsys_ev_mon;

  localparam int LUI = 0, JAL = 2, BEQ = 4, LW = 12, SW = 17, ADDI = 18, ADD = 27, TRAP = 48;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [48:0] instr = '0;
  logic        dbg = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] next_pc = '0;
  logic [48:0] ev;

  logic [48:0] exp_ev = '0;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_npc = '0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic        dbg;
    logic [48:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [48:0] want_ev;
    logic [31:0] want_pc;
    logic [31:0] want_npc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  riscvsys_ev_mon #(.PC_W(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_instr_lui(instr[0]), .i_instr_auipc(instr[1]), .i_instr_jal(instr[2]), .i_instr_jalr(instr[3]),
    .i_instr_beq(instr[4]), .i_instr_bne(instr[5]), .i_instr_blt(instr[6]), .i_instr_bge(instr[7]),
    .i_instr_bltu(instr[8]), .i_instr_bgeu(instr[9]), .i_instr_lb(instr[10]), .i_instr_lh(instr[11]),
    .i_instr_lw(instr[12]), .i_instr_lbu(instr[13]), .i_instr_lhu(instr[14]), .i_instr_sb(instr[15]),
    .i_instr_sh(instr[16]), .i_instr_sw(instr[17]), .i_instr_addi(instr[18]), .i_instr_slti(instr[19]),
    .i_instr_sltiu(instr[20]), .i_instr_xori(instr[21]), .i_instr_ori(instr[22]), .i_instr_andi(instr[23]),
    .i_instr_slli(instr[24]), .i_instr_srli(instr[25]), .i_instr_srai(instr[26]), .i_instr_add(instr[27]),
    .i_instr_sub(instr[28]), .i_instr_sll(instr[29]), .i_instr_slt(instr[30]), .i_instr_sltu(instr[31]),
    .i_instr_xor(instr[32]), .i_instr_srl(instr[33]), .i_instr_sra(instr[34]), .i_instr_or(instr[35]),
    .i_instr_and(instr[36]), .i_instr_rdcycle(instr[37]), .i_instr_rdcycleh(instr[38]),
    .i_instr_rdinstr(instr[39]), .i_instr_rdinstrh(instr[40]), .i_instr_ecall_ebreak(instr[41]),
    .i_instr_getq(instr[42]), .i_instr_setq(instr[43]), .i_instr_retirq(instr[44]),
    .i_instr_maskirq(instr[45]), .i_instr_waitirq(instr[46]), .i_instr_timer(instr[47]),
    .i_instr_trap(instr[48]),
    .i_pc(pc), .i_next_pc(next_pc), .i_dbg_next(dbg),
    .ev_lui(ev[0]), .ev_auipc(ev[1]), .ev_jal(ev[2]), .ev_jalr(ev[3]),
    .ev_beq(ev[4]), .ev_bne(ev[5]), .ev_blt(ev[6]), .ev_bge(ev[7]),
    .ev_bltu(ev[8]), .ev_bgeu(ev[9]), .ev_lb(ev[10]), .ev_lh(ev[11]),
    .ev_lw(ev[12]), .ev_lbu(ev[13]), .ev_lhu(ev[14]), .ev_sb(ev[15]),
    .ev_sh(ev[16]), .ev_sw(ev[17]), .ev_addi(ev[18]), .ev_slti(ev[19]),
    .ev_sltiu(ev[20]), .ev_xori(ev[21]), .ev_ori(ev[22]), .ev_andi(ev[23]),
    .ev_slli(ev[24]), .ev_srli(ev[25]), .ev_srai(ev[26]), .ev_add(ev[27]),
    .ev_sub(ev[28]), .ev_sll(ev[29]), .ev_slt(ev[30]), .ev_sltu(ev[31]),
    .ev_xor(ev[32]), .ev_srl(ev[33]), .ev_sra(ev[34]), .ev_or(ev[35]),
    .ev_and(ev[36]), .ev_rdcycle(ev[37]), .ev_rdcycleh(ev[38]),
    .ev_rdinstr(ev[39]), .ev_rdinstrh(ev[40]), .ev_ecall_ebreak(ev[41]),
    .ev_getq(ev[42]), .ev_setq(ev[43]), .ev_retirq(ev[44]),
    .ev_maskirq(ev[45]), .ev_waitirq(ev[46]), .ev_timer(ev[47]),
    .ev_trap(ev[48])
  );

  function automatic logic [48:0] bit_of(input int idx);
    logic [48:0] one;
    one = 49'd1;
    return one << idx;
  endfunction

  // Drive one cycle of inputs, let the edge happen, then update the reference:
  // an event is simply "what was decoded on a launch cycle", and PCs follow launches.
  task automatic applyStimulus(input logic d, input logic [48:0] f,
                               input logic [31:0] p, input logic [31:0] np);
    dbg = d; instr = f; pc = p; next_pc = np;
    @(posedge clk);
    if (rst) begin
      exp_ev = '0; exp_pc = '0; exp_npc = '0;
    end else begin
      exp_ev = d ? f : '0;
      if (d) begin exp_pc = p; exp_npc = np; end
    end
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [48:0] want);
    total++;
    if (ev !== want) begin
      bad++;
      $display("[TB] FAIL %s: ev=%h want=%h", name, ev, want);
    end
  endtask

  task automatic checkPc(input string name, input logic [31:0] wpc, input logic [31:0] wnpc);
    total++;
    if (dut.last_pc !== wpc || dut.last_next_pc !== wnpc) begin
      bad++;
      $display("[TB] FAIL %s: last_pc=%h last_next_pc=%h want %h %h",
               name, dut.last_pc, dut.last_next_pc, wpc, wnpc);
    end
  endtask

  task automatic addVec(input logic d, input logic [48:0] f, input logic [31:0] p,
                        input logic [31:0] np, input logic [48:0] we,
                        input logic [31:0] wp, input logic [31:0] wnp);
    vec_t v;
    v.dbg = d; v.instr = f; v.pc = p; v.npc = np;
    v.want_ev = we; v.want_pc = wp; v.want_npc = wnp;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: sim time expired, want completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pulses;
    logic [48:0] all_ones;
    all_ones = '1;

    addVec(1, bit_of(ADDI), 32'h100, 32'h104, bit_of(ADDI), 32'h100, 32'h104);
    addVec(0, bit_of(ADDI), 32'h200, 32'h204, '0, 32'h100, 32'h104);
    addVec(1, bit_of(JAL) | bit_of(TRAP), 32'h300, 32'h3f0, bit_of(JAL) | bit_of(TRAP), 32'h300, 32'h3f0);
    addVec(1, '0, 32'h400, 32'h404, '0, 32'h400, 32'h404);
    addVec(0, all_ones, 32'h500, 32'h504, '0, 32'h400, 32'h404);
    addVec(1, all_ones, 32'h100, 32'h104, all_ones, 32'h100, 32'h104);
    addVec(1, bit_of(ADDI), 32'hffff_fff0, 32'h0, bit_of(ADDI), 32'hffff_fff0, 32'h0);
    addVec(1, bit_of(LUI), 32'h0, 32'h4, bit_of(LUI), 32'h0, 32'h4);
    addVec(1, bit_of(TRAP), 32'h10, 32'h14, bit_of(TRAP), 32'h10, 32'h14);

    // Reset state, with launch activity present while reset is held.
    applyStimulus(1, bit_of(ADD), 32'h44, 32'h48);
    applyStimulus(1, bit_of(ADD), 32'h44, 32'h48);
    checkOutput("reset_state", '0);
    checkPc("reset_pc", '0, '0);
    rst = 1'b0;

    // Single launch on the fifth edge after reset release.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, bit_of(ADDI), 32'h8, 32'hc);
      checkOutput("flags_no_launch", '0);
    end
    applyStimulus(1, bit_of(ADDI), 32'h100, 32'h104);
    checkOutput("single_launch", bit_of(ADDI));
    applyStimulus(0, '0, 32'h0, 32'h0);
    checkOutput("single_launch_end", '0);
    checkPc("pc_capture", 32'h100, 32'h104);

    // Multi-cycle load: one pulse over the whole hold.
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i == 0, bit_of(LW), 32'h20, 32'h24);
      checkOutput("lw_hold", i == 0 ? bit_of(LW) : 49'd0);
      if (ev[LW]) pulses++;
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("[TB] FAIL lw_pulse_count: got %0d want 1", pulses);
    end

    // Back-to-back sw, sw, beq.
    applyStimulus(1, bit_of(SW), 32'h30, 32'h34);
    checkOutput("b2b_sw1", bit_of(SW));
    applyStimulus(1, bit_of(SW), 32'h34, 32'h38);
    checkOutput("b2b_sw2", bit_of(SW));
    applyStimulus(1, bit_of(BEQ), 32'h38, 32'h3c);
    checkOutput("b2b_beq", bit_of(BEQ));
    applyStimulus(0, '0, 32'h0, 32'h0);
    checkOutput("b2b_idle", '0);
    checkPc("b2b_pc", 32'h38, 32'h3c);

    // Table vectors.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].dbg, vecs[i].instr, vecs[i].pc, vecs[i].npc);
      checkOutput($sformatf("vec%0d_ev", i), vecs[i].want_ev);
      checkPc($sformatf("vec%0d_pc", i), vecs[i].want_pc, vecs[i].want_npc);
    end

    // Asynchronous reset mid-cycle drops an in-flight pulse.
    applyStimulus(1, bit_of(ADD), 32'h60, 32'h64);
    checkOutput("pre_reset_add", bit_of(ADD));
    #2 rst = 1'b1;
    #1;
    exp_ev = '0; exp_pc = '0; exp_npc = '0;
    checkOutput("async_reset", '0);
    checkPc("async_reset_pc", '0, '0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, bit_of(ADD), 32'h70, 32'h74);
      checkOutput("in_reset", '0);
      checkPc("in_reset_pc", '0, '0);
    end
    rst = 1'b0;
    applyStimulus(1, bit_of(ADD), 32'h80, 32'h84);
    checkOutput("post_reset_first", bit_of(ADD));

    // Randomized launches against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic        d;
      logic [48:0] f;
      int          mode;
      d = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 3);
      case (mode)
        0: f = '0;
        1: f = bit_of($urandom_range(0, 48));
        2: f = bit_of($urandom_range(0, 48)) | bit_of($urandom_range(0, 48));
        default: f = {17'($urandom), $urandom};
      endcase
      applyStimulus(d, f, $urandom, $urandom);
      checkOutput("random_ev", exp_ev);
      checkPc("random_pc", exp_pc, exp_npc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
